bcd_digit_scan: RTL

Multi-digit display scan controller that sits directly upstream of the BCD-to-7-segment decoder. It holds a packed multi-digit BCD value and time-multiplexes one digit at a time onto a 4-bit BCD bus feeding the decoder's bcd_in. It also drives one-hot active-high digit enables for the common pins of the display.
New values are double-buffered and committed only at frame boundaries, so a displayed frame never tears.

---
 rtl/bcd_digit_scan_if.sv | 22 ++
 rtl/bcd_digit_scan.sv | 107 ++++++++++
 2 files changed

// File: rtl/bcd_digit_scan_if.sv
// rtl/bcd_digit_scan_if.sv - load and display-scan signal bundle for bcd_digit_scan
interface bcd_digit_scan_if #(
  parameter int N_DIGITS = 4
);
  logic                  load;
  logic [4*N_DIGITS-1:0] load_value;
  logic                  load_err;
  logic                  pending;
  logic [3:0]            bcd_out;
  logic [N_DIGITS-1:0]   digit_en;
  logic                  frame_tick;

  modport master (
    output load, load_value,
    input  load_err, pending, bcd_out, digit_en, frame_tick
  );

  modport slave (
    input  load, load_value,
    output load_err, pending, bcd_out, digit_en, frame_tick
  );
endinterface

// File: rtl/bcd_digit_scan.sv
// rtl/bcd_digit_scan.sv - time-multiplexed BCD digit scanner with frame-synchronous double buffering
// Optional macro LEADING_ZERO_BLANK_EN blanks the enables of leading zero digits.
module bcd_digit_scan #(
  parameter int N_DIGITS = 4,
  parameter int PRESCALE = 50000,
  parameter int GUARD    = 4
) (
  input logic             clk,
  input logic             rst,
  bcd_digit_scan_if.slave bus
);
  localparam int CW = $clog2(PRESCALE);
  localparam int IW = $clog2(N_DIGITS);
  localparam int DW = 4 * N_DIGITS;
  localparam logic [CW-1:0] PRE_LAST = CW'(PRESCALE - 1);
  localparam logic [IW-1:0] DIG_LAST = IW'(N_DIGITS - 1);

  logic [CW-1:0]       pre_cnt, nxt_pre;
  logic [IW-1:0]       digit_idx, nxt_idx;
  logic [DW-1:0]       display, nxt_disp;
  logic [DW-1:0]       pend_buf, nxt_pbuf;
  logic                pending_q, nxt_pend;
  logic                load_ok, wrap, fb;
  logic [3:0]          nxt_bcd, bcd_q;
  logic [N_DIGITS-1:0] nxt_en, en_q;
  logic                nxt_tick, tick_q, err_q;
`ifdef LEADING_ZERO_BLANK_EN
  logic                seen_nz;
`endif

  always_comb begin
    wrap    = (pre_cnt == PRE_LAST);
    fb      = wrap && (digit_idx == DIG_LAST);
    nxt_pre = wrap ? '0 : pre_cnt + 1'b1;
    nxt_idx = digit_idx;
    if (wrap) nxt_idx = (digit_idx == DIG_LAST) ? '0 : digit_idx + 1'b1;

    load_ok = 1'b1;
    for (int k = 0; k < N_DIGITS; k++)
      if (bus.load_value[4*k +: 4] > 4'd9) load_ok = 1'b0;

    // A valid load on the frame boundary bypasses the buffer and wins over it.
    nxt_disp = display;
    nxt_pbuf = pend_buf;
    nxt_pend = pending_q;
    if (bus.load && load_ok) begin
      if (fb) begin
        nxt_disp = bus.load_value;
        nxt_pend = 1'b0;
      end else begin
        nxt_pbuf = bus.load_value;
        nxt_pend = 1'b1;
      end
    end else if (fb && pending_q) begin
      nxt_disp = pend_buf;
      nxt_pend = 1'b0;
    end

    // Outputs are registered, so they are derived from the next-state values.
    nxt_bcd = 4'd0;
    nxt_en  = '0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (nxt_idx == IW'(k)) begin
        nxt_bcd   = nxt_disp[4*k +: 4];
        nxt_en[k] = (int'(nxt_pre) >= GUARD);
      end
    end
`ifdef LEADING_ZERO_BLANK_EN
    seen_nz = 1'b0;
    for (int k = N_DIGITS - 1; k >= 1; k--) begin
      seen_nz = seen_nz | (nxt_disp[4*k +: 4] != 4'd0);
      if (!seen_nz) nxt_en[k] = 1'b0;
    end
`endif
    nxt_tick = (nxt_pre == '0) && (nxt_idx == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt   <= '0;
      digit_idx <= '0;
      display   <= '0;
      pend_buf  <= '0;
      pending_q <= 1'b0;
      bcd_q     <= 4'd0;
      en_q      <= '0;
      tick_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      pre_cnt   <= nxt_pre;
      digit_idx <= nxt_idx;
      display   <= nxt_disp;
      pend_buf  <= nxt_pbuf;
      pending_q <= nxt_pend;
      bcd_q     <= nxt_bcd;
      en_q      <= nxt_en;
      tick_q    <= nxt_tick;
      err_q     <= bus.load && !load_ok;
    end
  end

  assign bus.bcd_out    = bcd_q;
  assign bus.digit_en   = en_q;
  assign bus.frame_tick = tick_q;
  assign bus.pending    = pending_q;
  assign bus.load_err   = err_q;
endmodule
